// File: rtl/conv_result_drain.sv
// Result frame buffer for the row-parallel convolution core: captures per-lane result
// writes until the frame-end write, then streams the frame out one result row per beat.
module conv_result_drain #(
  parameter  int DATA_WIDTH          = 8,
  parameter  int RESULT_W            = 6,
  parameter  int RESULT_H            = 6,
  parameter  int RESULT_D            = 4,
  localparam int RESULT_H_ADDR_WIDTH = (RESULT_H > 1) ? $clog2(RESULT_H) : 1,
  localparam int RESULT_D_ADDR_WIDTH = (RESULT_D > 1) ? $clog2(RESULT_D) : 1,
  localparam int NUM_LANES           = RESULT_D * RESULT_W
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_LANES*RESULT_H_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_LANES-1:0]                     wr_en,
  output logic                                     frame_rdy,
  output logic                                     out_val,
  input  logic                                     out_rdy,
  output logic [RESULT_W*DATA_WIDTH-1:0]           out_data,
  output logic [RESULT_D_ADDR_WIDTH-1:0]           out_d,
  output logic [RESULT_H_ADDR_WIDTH-1:0]           out_h,
  output logic                                     out_last,
  output logic                                     frame_done,
  output logic                                     err,
  output logic                                     dbg_state
);

  localparam int HAW = RESULT_H_ADDR_WIDTH;
  localparam int DAW = RESULT_D_ADDR_WIDTH;
  localparam logic [HAW-1:0] H_LAST = HAW'(RESULT_H - 1);
  localparam logic [DAW-1:0] D_LAST = DAW'(RESULT_D - 1);

  // Output handshake: a beat transfers on a cycle where out_val && out_rdy; while
  // out_val=1 and out_rdy=0 the beat (data, indices, last) is held unchanged.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DRAIN   = 1'b1
  } state_t;

  state_t                r_state;
  logic [DAW-1:0]        r_d;
  logic [HAW-1:0]        r_h;
  logic                  r_out_val;
  logic                  r_frame_rdy;
  logic                  r_frame_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [RESULT_D][RESULT_H][RESULT_W];

  logic [HAW-1:0]        w_lane_addr [NUM_LANES];
  logic [DATA_WIDTH-1:0] w_lane_data [NUM_LANES];
  logic [NUM_LANES-1:0]  w_lane_ok;
  logic [NUM_LANES-1:0]  w_lane_bad;
  logic                  w_collect;
  logic                  w_frame_end;
  logic                  w_accept;
  logic                  w_err_set;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      w_lane_addr[l] = wr_addr[l*HAW +: HAW];
      w_lane_data[l] = wr_data[l*DATA_WIDTH +: DATA_WIDTH];
      w_lane_ok[l]   = wr_en[l] && (w_lane_addr[l] <= H_LAST);
      w_lane_bad[l]  = wr_en[l] && (w_lane_addr[l] >  H_LAST);
    end
  end

  assign w_collect   = (r_state == ST_COLLECT);
  // The last lane of the last channel writing the last row closes the frame.
  assign w_frame_end = w_collect && wr_en[NUM_LANES-1] && (w_lane_addr[NUM_LANES-1] == H_LAST);
  assign w_accept    = r_out_val && out_rdy;
  assign w_err_set   = w_collect ? (|w_lane_bad) : (|wr_en);

  // Storage is deliberately not reset; it is fully defined again by the next frame.
  always_ff @(posedge clk) begin
    if (w_collect) begin
      for (int d = 0; d < RESULT_D; d++) begin
        for (int w = 0; w < RESULT_W; w++) begin
          if (w_lane_ok[d*RESULT_W + w]) begin
            r_mem[d][w_lane_addr[d*RESULT_W + w]][w] <= w_lane_data[d*RESULT_W + w];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_COLLECT;
      r_d          <= '0;
      r_h          <= '0;
      r_out_val    <= 1'b0;
      r_frame_rdy  <= 1'b1;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_COLLECT: begin
          if (w_frame_end) begin
            r_state     <= ST_DRAIN;
            r_out_val   <= 1'b1;
            r_frame_rdy <= 1'b0;
            r_d         <= '0;
            r_h         <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_accept) begin
            if (r_h == H_LAST) begin
              r_h <= '0;
              if (r_d == D_LAST) begin
                r_d          <= '0;
                r_state      <= ST_COLLECT;
                r_out_val    <= 1'b0;
                r_frame_rdy  <= 1'b1;
                r_frame_done <= 1'b1;
              end else begin
                r_d <= r_d + DAW'(1);
              end
            end else begin
              r_h <= r_h + HAW'(1);
            end
          end
        end
        default: begin
          r_state     <= ST_COLLECT;
          r_out_val   <= 1'b0;
          r_frame_rdy <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int w = 0; w < RESULT_W; w++) begin
      out_data[w*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_d][r_h][w];
    end
  end

  assign out_d      = r_d;
  assign out_h      = r_h;
  assign out_last   = r_out_val && (r_d == D_LAST) && (r_h == H_LAST);
  assign out_val    = r_out_val;
  assign frame_rdy  = r_frame_rdy;
  assign frame_done = r_frame_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_result_drain.sv
// Bench for conv_result_drain: random lane-masked frames and consumer stalls checked
// against a frame-level model (element array plus expected-beat queue).
module tb_conv_result_drain;

  localparam int DW  = 8;
  localparam int RW  = 3;
  localparam int RH  = 3;
  localparam int RD  = 2;
  localparam int HAW = 2;
  localparam int DAW = 1;
  localparam int NL  = RD * RW;
  localparam int BW  = DAW + HAW + 1 + RW * DW;

  logic              clk = 1'b0;
  logic              reset;
  logic [NL*HAW-1:0] wr_addr;
  logic [NL*DW-1:0]  wr_data;
  logic [NL-1:0]     wr_en;
  logic              frame_rdy;
  logic              out_val;
  logic              out_rdy;
  logic [RW*DW-1:0]  out_data;
  logic [DAW-1:0]    out_d;
  logic [HAW-1:0]    out_h;
  logic              out_last;
  logic              frame_done;
  logic              err;
  logic              dbg_state;

  conv_result_drain #(
    .DATA_WIDTH(DW), .RESULT_W(RW), .RESULT_H(RH), .RESULT_D(RD)
  ) dut (
    .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .frame_rdy(frame_rdy), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .out_d(out_d), .out_h(out_h), .out_last(out_last), .frame_done(frame_done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [DW-1:0] m_mem [RD][RH][RW];
  bit          m_collect = 1'b1;
  bit          m_err     = 1'b0;
  bit          m_fd      = 1'b0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] beat_word(input int d, input int h);
    logic [RW*DW-1:0] row;
    logic             last;
    for (int w = 0; w < RW; w++) row[w*DW +: DW] = m_mem[d][h][w];
    last = (d == RD - 1) && (h == RH - 1);
    return {DAW'(d), HAW'(h), last, row};
  endfunction

  // One clock: check outputs at the negedge, advance the model for the coming edge.
  task automatic cycle();
    logic [BW-1:0]  head;
    logic [HAW-1:0] a;
    @(negedge clk);
    check("frame_rdy", frame_rdy, m_collect);
    check("out_val", out_val, !m_collect);
    check("frame_done", frame_done, m_fd);
    check("err", err, m_err);
    check("dbg_state", dbg_state, !m_collect);
    if (!m_collect) begin
      check("beat_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("beat", {out_d, out_h, out_last, out_data}, exp_q[0]);
    end
    m_fd = 1'b0;
    if (m_collect) begin
      for (int l = 0; l < NL; l++) begin
        if (wr_en[l]) begin
          a = wr_addr[l*HAW +: HAW];
          if (int'(a) < RH) m_mem[l / RW][a][l % RW] = wr_data[l*DW +: DW];
          else m_err = 1'b1;
        end
      end
      if (wr_en[NL-1] && int'(wr_addr[(NL-1)*HAW +: HAW]) == RH - 1) begin
        for (int d = 0; d < RD; d++)
          for (int h = 0; h < RH; h++) exp_q.push_back(beat_word(d, h));
        m_collect = 1'b0;
      end
    end else begin
      if (|wr_en) m_err = 1'b1;
      if (out_rdy && exp_q.size() > 0) begin
        head = exp_q.pop_front();
        if (head[RW*DW]) begin
          m_collect = 1'b1;
          m_fd      = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic drive_idle();
    wr_en   = '0;
    wr_addr = NL*HAW'($urandom);
    wr_data = {$urandom, $urandom};
  endtask

  task automatic drive_write(input logic [NL-1:0] mask, input int h, input logic [7:0] salt);
    wr_en = mask;
    for (int l = 0; l < NL; l++) begin
      if (mask[l]) begin
        wr_addr[l*HAW +: HAW] = HAW'(h);
        wr_data[l*DW +: DW]   = salt + 8'((l / RW) * 16 + h * 4 + (l % RW));
      end else begin
        wr_addr[l*HAW +: HAW] = HAW'($urandom_range(0, 3));
        wr_data[l*DW +: DW]   = 8'($urandom);
      end
    end
  endtask

  task automatic write_frame(input logic [7:0] salt, input bit full_rows);
    logic [NL-1:0] pending;
    logic [NL-1:0] mask;
    for (int h = 0; h < RH; h++) begin
      pending = '1;
      if (h == RH - 1 && !full_rows) pending[NL-1] = 1'b0;
      while (pending != '0) begin
        mask = full_rows ? pending : (NL'($urandom) & pending);
        if (mask == '0) mask = pending;
        drive_write(mask, h, salt);
        out_rdy = 1'($urandom);
        cycle();
        pending &= ~mask;
        if (!full_rows && $urandom_range(0, 3) == 0) begin
          drive_idle();
          cycle();
        end
      end
      if (h == RH - 1 && !full_rows) begin
        drive_write(NL'(1) << (NL - 1), h, salt);
        cycle();
      end
    end
    drive_idle();
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
  task automatic drain_frame(input int mode, input bit inject);
    int i = 0;
    while (!m_collect && i < 200) begin
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (i % 3 == 0);
        default: out_rdy = 1'($urandom);
      endcase
      if (inject) begin
        wr_en   = '1;
        wr_data = '1;
        for (int l = 0; l < NL; l++) wr_addr[l*HAW +: HAW] = HAW'($urandom_range(0, RH - 1));
      end else begin
        drive_idle();
      end
      cycle();
      i++;
    end
    check("drain_done", m_collect, 1);
    drive_idle();
    out_rdy = 1'b0;
    cycle();
  endtask

  task automatic apply_reset();
    drive_idle();
    out_rdy = 1'b0;
    reset   = 1'b0;
    #2;
    check("rst_out_val", out_val, 0);
    check("rst_frame_rdy", frame_rdy, 1);
    check("rst_err", err, 0);
    check("rst_frame_done", frame_done, 0);
    m_collect = 1'b1;
    m_err     = 1'b0;
    m_fd      = 1'b0;
    exp_q.delete();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    out_rdy = 1'b0;
    drive_idle();
    #6;
    apply_reset();

    // mid-run reset with a partial frame and an out-of-range write pending
    drive_write('1, 0, 8'h33);
    cycle();
    drive_write(NL'(1) << 2, 0, 8'h33);
    wr_addr[2*HAW +: HAW] = 2'd3;
    cycle();
    drive_idle();
    apply_reset();

    // full rows, in-order drain, explicit last beat check
    write_frame(8'h00, 1'b1);
    out_rdy = 1'b1;
    repeat (5) cycle();
    check("t2_last_data", out_data, 24'h1A1918);
    check("t2_last_flag", out_last, 1);
    check("t2_last_idx", {out_d, out_h}, {1'b1, 2'd2});
    drain_frame(0, 1'b0);

    // stalled consumer
    write_frame(8'h00, 1'b1);
    drain_frame(1, 1'b0);

    // random lane masks and random backpressure
    for (int f = 0; f < 4; f++) begin
      write_frame(8'($urandom), 1'b0);
      drain_frame(2, 1'b0);
    end

    // back-to-back frames, then reset mid-drain and restart
    write_frame(8'h40, 1'b0);
    drain_frame(0, 1'b0);
    write_frame(8'h80, 1'b0);
    drain_frame(2, 1'b0);
    write_frame(8'hC0, 1'b1);
    out_rdy = 1'b1;
    repeat (3) cycle();
    apply_reset();
    write_frame(8'h55, 1'b0);
    drain_frame(2, 1'b0);

    // writes during drain are dropped and flag err
    write_frame(8'h20, 1'b1);
    drain_frame(2, 1'b1);
    apply_reset();

    // out-of-range lane write while collecting
    drive_write(NL'(1) << 2, 0, 8'h00);
    wr_addr[2*HAW +: HAW] = 2'd3;
    cycle();
    drive_idle();
    cycle();
    write_frame(8'h66, 1'b1);
    drain_frame(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
